// File: rtl/matrix_vector_mac.sv
// DIM x DIM signed fixed-point matrix-vector multiply with one column per cycle.
// Define MVM_SATURATE_EN to clamp out-of-range lanes; otherwise they wrap to WIDTH bits.
module matrix_vector_mac #(
  parameter int DIM       = 4,
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     start,
  input  logic signed [DIM-1:0][DIM-1:0][WIDTH-1:0] m1,
  input  logic signed [DIM-1:0][WIDTH-1:0]          v1,
  output logic signed [DIM-1:0][WIDTH-1:0]          v_out,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     overflow,
  output logic [1:0]                               state_dbg
);

  // Handshake: start is sampled only while idle (busy=0). busy stays high from
  // the accepting edge until the result edge. done pulses for exactly one cycle
  // when v_out/overflow update, and a new start may be given in that cycle.

  localparam int ACC_W  = 2*WIDTH + $clog2(DIM);
  localparam int PROD_W = 2*WIDTH;
  localparam int COL_W  = $clog2(DIM);
  localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

  localparam logic signed [ACC_W-1:0] RND_K =
    (FRAC_BITS > 0) ? (ACC_W'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_next;

  logic signed [DIM-1:0][DIM-1:0][WIDTH-1:0] m_lat;
  logic signed [DIM-1:0][WIDTH-1:0]          v_lat;
  logic [COL_W-1:0]                          col;

  logic signed [ACC_W-1:0]  acc      [DIM];
  logic signed [ACC_W-1:0]  acc_next [DIM];
  logic signed [PROD_W-1:0] prod     [DIM];
  logic signed [PROD_W-1:0] m_ext    [DIM];
  logic signed [PROD_W-1:0] v_ext;
  logic signed [ACC_W-1:0]  rounded  [DIM];
  logic signed [ACC_W-1:0]  shifted  [DIM];
  logic [WIDTH-1:0]         lane_val [DIM];
  logic [DIM-1:0]           lane_ovf;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (col == COL_W'(DIM-1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // Per-lane MAC step and finishing arithmetic
  always_comb begin
    v_ext = {{WIDTH{v_lat[col][WIDTH-1]}}, v_lat[col]};
    for (int r = 0; r < DIM; r++) begin
      m_ext[r]    = {{WIDTH{m_lat[r][col][WIDTH-1]}}, m_lat[r][col]};
      prod[r]     = m_ext[r] * v_ext;
      acc_next[r] = acc[r] + {{(ACC_W-PROD_W){prod[r][PROD_W-1]}}, prod[r]};
      rounded[r]  = acc[r] + RND_K;
      shifted[r]  = rounded[r] >>> FRAC_BITS;
      lane_ovf[r] = (shifted[r] > MAX_V) || (shifted[r] < MIN_V);
`ifdef MVM_SATURATE_EN
      if (shifted[r] > MAX_V)      lane_val[r] = MAX_V[WIDTH-1:0];
      else if (shifted[r] < MIN_V) lane_val[r] = MIN_V[WIDTH-1:0];
      else                         lane_val[r] = shifted[r][WIDTH-1:0];
`else
      lane_val[r] = shifted[r][WIDTH-1:0];
`endif
    end
  end

  // Datapath registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      m_lat    <= '0;
      v_lat    <= '0;
      col      <= '0;
      v_out    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      for (int r = 0; r < DIM; r++) acc[r] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_lat <= m1;
            v_lat <= v1;
            col   <= '0;
            for (int r = 0; r < DIM; r++) acc[r] <= '0;
          end
        end
        ACCUM: begin
          col <= col + COL_W'(1);
          for (int r = 0; r < DIM; r++) acc[r] <= acc_next[r];
        end
        FINISH: begin
          for (int r = 0; r < DIM; r++) v_out[r] <= lane_val[r];
          overflow <= |lane_ovf;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_vector_mac.sv
// Scoreboarded bench for matrix_vector_mac: a Q16.16 4x4 instance and a
// Q8.8 2x2 instance used for the overflow case.
module tb_matrix_vector_mac;

  localparam int DIM = 4;
  localparam int W   = 32;
  localparam int SD  = 2;
  localparam int SW  = 16;
  localparam int RW  = DIM*W + 1;

  typedef logic signed [DIM-1:0][DIM-1:0][W-1:0] mat_t;
  typedef logic signed [DIM-1:0][W-1:0]          vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in;
  logic start, start_s;
  mat_t m1;
  vec_t v1;
  vec_t v_out;
  logic busy, done, overflow;
  logic [1:0] state_dbg;

  logic signed [SD-1:0][SD-1:0][SW-1:0] m1_s;
  logic signed [SD-1:0][SW-1:0]         v1_s;
  logic signed [SD-1:0][SW-1:0]         v_out_s;
  logic busy_s, done_s, overflow_s;
  logic [1:0] state_dbg_s;

  matrix_vector_mac u_dut (
    .clk_in(clk), .rst_in(rst_in), .start(start), .m1(m1), .v1(v1),
    .v_out(v_out), .busy(busy), .done(done), .overflow(overflow),
    .state_dbg(state_dbg)
  );

  matrix_vector_mac #(.DIM(SD), .WIDTH(SW), .FRAC_BITS(8)) u_small (
    .clk_in(clk), .rst_in(rst_in), .start(start_s), .m1(m1_s), .v1(v1_s),
    .v_out(v_out_s), .busy(busy_s), .done(done_s), .overflow(overflow_s),
    .state_dbg(state_dbg_s)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [RW-1:0]      exp_q[$];
  logic [SD*SW:0]     exp_s_q[$];

  mat_t m_a, m_r;
  vec_t v_a, v_r;
  logic [RW-1:0] exp_a, exp_r;
  logic [SD*SW:0] exp_s;

  task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] q16(input real r);
    return 32'($rtoi(r * 65536.0));
  endfunction

  // Monitor: pops and compares whenever either instance presents a result
  always @(negedge clk) begin : monitor
    logic [RW-1:0] e;
    logic [SD*SW:0] es;
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=%h exp=none", {overflow, v_out});
      end else begin
        e = exp_q.pop_front();
        check("result", {overflow, v_out}, e);
      end
    end
    if (done_s === 1'b1) begin
      if (exp_s_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done_s got=%h exp=none", {overflow_s, v_out_s});
      end else begin
        es = exp_s_q.pop_front();
        check("result_s", RW'({overflow_s, v_out_s}), RW'(es));
      end
    end
  end

  task automatic scramble_inputs();
    for (int r = 0; r < DIM; r++) begin
      v1[r] = $urandom;
      for (int c = 0; c < DIM; c++) m1[r][c] = $urandom;
    end
  endtask

  // Present one start pulse; returns 1 time unit after the accepting edge
  task automatic start_op(input mat_t m, input vec_t v, input logic [RW-1:0] exp, input bit push);
    m1 = m;
    v1 = v;
    start = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    check("busy_rise", RW'(busy), RW'(1'b1));
  endtask

  // Walk n edges after the start edge checking busy/done timing; optionally
  // checks v_out holding a prior value, and re-pulses start after edge inject_at
  task automatic track(input int n, input int done_at, input bit chk_hold,
                       input logic [RW-1:0] hold, input int inject_at);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (i == inject_at + 1) begin
        start = 1'b0;
        scramble_inputs();
      end
      check("busy", RW'(busy), RW'(i < done_at));
      check("done", RW'(done), RW'(i == done_at));
      if (chk_hold && i < done_at) check("v_out_hold", RW'(v_out), RW'(hold[DIM*W-1:0]));
      if (i == inject_at) begin
        m1 = m_r;
        v1 = v_r;
        start = 1'b1;
      end
    end
  endtask

  initial begin
    int base;
    rst_in = 1'b1; start = 1'b0; start_s = 1'b0;
    m1 = '0; v1 = '0; m1_s = '0; v1_s = '0;

    m_a[0] = {q16(4.0),  q16(3.0),    q16(2.0),    q16(-1.0)};
    m_a[1] = {q16(8.0),  q16(7.75),   q16(6.5),    q16(5.0)};
    m_a[2] = {q16(12.0), q16(-26.25), q16(10.0),   q16(9.0)};
    m_a[3] = {q16(16.0), q16(15.0),   q16(14.125), q16(13.0)};
    v_a    = {q16(12.0), q16(7.75),   q16(6.5),    q16(-3.5)};
    exp_a  = {1'b0, 32'h01629000, 32'hFFE61000, 32'h00B4D000, 32'h0057C000};

    m_r = '0;
    for (int r = 0; r < DIM; r++) m_r[r][r] = 32'h00008000;
    v_r   = {32'h00000000, 32'h00000003, 32'hFFFFFFFF, 32'h00000001};
    exp_r = {1'b0, 32'h00000000, 32'h00000002, 32'h00000000, 32'h00000001};

`ifdef MVM_SATURATE_EN
    exp_s = {1'b1, 16'h7FFF, 16'h7FFF};
`else
    exp_s = {1'b1, 16'h0200, 16'h0200};
`endif

    repeat (2) @(posedge clk);
    #1 rst_in = 1'b0;
    check("reset_v_out", RW'(v_out), '0);
    check("reset_busy", RW'(busy), '0);
    check("reset_done", RW'(done), '0);
    check("reset_overflow", RW'(overflow), '0);
    check("reset_state", RW'(state_dbg), '0);
    check("reset_small", RW'({overflow_s, busy_s, done_s, v_out_s}), '0);

    // Q16.16 reference product and its latency
    start_op(m_a, v_a, exp_a, 1'b1);
    track(DIM+1, DIM+1, 1'b0, '0, 0);
    repeat (2) @(posedge clk); #1;

    // Round-half-up behaviour on tiny values
    start_op(m_r, v_r, exp_r, 1'b1);
    track(DIM+1, DIM+1, 1'b1, exp_a, 0);
    repeat (2) @(posedge clk); #1;

    // Second start during ACCUM must be ignored
    base = done_cnt;
    start_op(m_a, v_a, exp_a, 1'b1);
    track(DIM+1, DIM+1, 1'b1, exp_r, 1);
    repeat (4) @(posedge clk); #1;
    check("busy_ignore_one_done", RW'(done_cnt - base), RW'(1));

    // Back-to-back: new start in the done cycle
    start_op(m_r, v_r, exp_r, 1'b1);
    track(DIM+1, DIM+1, 1'b0, '0, 0);
    start_op(m_a, v_a, exp_a, 1'b1);
    track(DIM+1, DIM+1, 1'b1, exp_r, 0);
    repeat (2) @(posedge clk); #1;

    // Overflow on the Q8.8 2x2 instance
    m1_s = {16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    v1_s = {16'h7F00, 16'h7F00};
    start_s = 1'b1;
    exp_s_q.push_back(exp_s);
    @(posedge clk); #1;
    start_s = 1'b0;
    m1_s = '0; v1_s = '0;
    for (int i = 1; i <= SD+1; i++) begin
      @(posedge clk); #1;
      check("done_s", RW'(done_s), RW'(i == SD+1));
    end
    repeat (2) @(posedge clk); #1;

    // Reset while ACCUM is at col=2
    base = done_cnt;
    start_op(m_a, v_a, exp_a, 1'b0);
    repeat (2) @(posedge clk); #1;
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    check("rst_mid_busy", RW'(busy), '0);
    check("rst_mid_v_out", RW'(v_out), '0);
    check("rst_mid_overflow", RW'(overflow), '0);
    check("rst_mid_state", RW'(state_dbg), '0);
    for (int i = 0; i < DIM+3; i++) begin
      @(posedge clk); #1;
      check("rst_mid_no_done", RW'(done), '0);
    end
    check("rst_mid_done_count", RW'(done_cnt - base), '0);
    start_op(m_a, v_a, exp_a, 1'b1);
    track(DIM+1, DIM+1, 1'b1, '0, 0);

    repeat (3) @(posedge clk); #1;
    check("queue_drain", RW'(exp_q.size() + exp_s_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
